// File: rtl/alu_ctrl_seq_pkg.sv
// Shared types for the alu control sequencer.
// FSM states, instruction classes, jump condition codes, HALT encoding.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    CL_ALU,
    CL_LOADI,
    CL_JMP
  } iclass_t;

  localparam logic [1:0] CC_Z  = 2'b00;
  localparam logic [1:0] CC_NZ = 2'b01;
  localparam logic [1:0] CC_C  = 2'b10;
  localparam logic [1:0] CC_AL = 2'b11;

  localparam logic [7:0] HALT_INSTR = 8'hFF;

  function automatic iclass_t get_class(
    input logic [7:0] ir
  );
    iclass_t c;
    c = CL_ALU;
    unique case (1'b1)
      !ir[7]:            c = CL_ALU;
      ir[7] && !ir[6]:   c = CL_LOADI;
      default:           c = CL_JMP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Sequencer <-> alu bundle: operands and control out, result and flags back.
// master = sequencer side, slave = alu side.
interface alu_ctrl_seq_if;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic       alu_l;
  logic [3:0] alu_r;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_sign;

  modport master (
    output alu_a, alu_b, alu_op, alu_l,
    input  alu_r, alu_zero, alu_carry, alu_sign
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_l,
    output alu_r, alu_zero, alu_carry, alu_sign
  );

endinterface

// File: rtl/alu_ctrl_seq_regfile.sv
// 4x4-bit register file: two async read ports, one debug read port,
// one synchronous write port, synchronous active-high reset to zero.
module regfile4x4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ra_sel,
  output logic [3:0] ra_data,
  input  logic [1:0] rb_sel,
  output logic [3:0] rb_data,
  input  logic [1:0] dbg_sel,
  output logic [3:0] dbg_data,
  input  logic       we,
  input  logic [1:0] wsel,
  input  logic [3:0] wdata
);

  logic [3:0] rf_q [4];
  logic [3:0] rf_d [4];

  assign ra_data  = rf_q[ra_sel];
  assign rb_data  = rf_q[rb_sel];
  assign dbg_data = rf_q[dbg_sel];

  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[wsel] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q <= '{default: '0};
    end else begin
      rf_q <= rf_d;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multicycle FETCH/DECODE/EXEC sequencer driving an external 4-bit alu.
// Ports: clk/reset, start, ROM pc/instr, alu bundle, flags, busy/halted, debug read.
module alu_ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int PC_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  input  logic [7:0]      instr,
  alu_ctrl_seq_if.master  alu,
  output logic            flag_z,
  output logic            flag_c,
  output logic            flag_s,
  output logic            busy,
  output logic            halted,
  input  logic [1:0]      dbg_sel,
  output logic [3:0]      dbg_data
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            fz_q, fz_d;
  logic            fc_q, fc_d;
  logic            fs_q, fs_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;

  logic            we;
  logic [1:0]      wsel;
  logic [3:0]      wdata;
  logic [3:0]      ra_data;
  logic [3:0]      rb_data;
  logic            cond_ok;
  logic [PC_W-1:0] off;
  iclass_t         cls;

  localparam logic [PC_W-1:0] PC_ONE =
    {{(PC_W-1){1'b0}}, 1'b1};

  regfile4x4 u_rf (
    .clk      (clk),
    .reset    (reset),
    .ra_sel   (ir_q[3:2]),
    .ra_data  (ra_data),
    .rb_sel   (ir_q[1:0]),
    .rb_data  (rb_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .we       (we),
    .wsel     (wsel),
    .wdata    (wdata)
  );

  assign cls = get_class(ir_q);
  // Jump offset is 4-bit signed, added to the already-incremented PC.
  assign off = {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};

  always_comb begin
    cond_ok = 1'b0;
    unique case (ir_q[5:4])
      CC_Z:    cond_ok = fz_q;
      CC_NZ:   cond_ok = !fz_q;
      CC_C:    cond_ok = fc_q;
      CC_AL:   cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    fz_d       = fz_q;
    fc_d       = fc_q;
    fs_d       = fs_q;
    busy_d     = busy_q;
    halted_d   = halted_q;
    we         = 1'b0;
    wsel       = 2'b00;
    wdata      = 4'h0;
    alu.alu_a  = 4'h0;
    alu.alu_b  = 4'h0;
    alu.alu_op = 2'b00;
    alu.alu_l  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d  = ST_FETCH;
          pc_d     = '0;
          busy_d   = 1'b1;
          halted_d = 1'b0;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
        ir_d    = instr;
        pc_d    = pc_q + PC_ONE;
      end
      ST_EXEC: begin
        if (ir_q == HALT_INSTR) begin
          state_d  = ST_HALTED;
          busy_d   = 1'b0;
          halted_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
          unique case (cls)
            CL_ALU: begin
              alu.alu_a  = ra_data;
              alu.alu_b  = rb_data;
              alu.alu_op = ir_q[5:4];
              alu.alu_l  = ir_q[6];
              we         = 1'b1;
              wsel       = ir_q[3:2];
              wdata      = alu.alu_r;
              fz_d       = alu.alu_zero;
              fc_d       = alu.alu_carry;
              fs_d       = alu.alu_sign;
            end
            CL_LOADI: begin
              we    = 1'b1;
              wsel  = ir_q[1:0];
              wdata = ir_q[5:2];
            end
            default: begin
              if (cond_ok) pc_d = pc_q + off;
            end
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= 8'h00;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fs_q     <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      fs_q     <= fs_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign flag_z = fz_q;
  assign flag_c = fc_q;
  assign flag_s = fs_q;
  assign busy   = busy_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench: sequencer + behavioural alu + behavioural 64x8 ROM.
// Programs are loaded into the ROM between runs while the DUT is idle/halted.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] pc;
  logic [7:0] instr;
  logic       flag_z, flag_c, flag_s;
  logic       busy, halted;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  logic [7:0] rom [64];

  int checks = 0;
  int failures = 0;

  alu_ctrl_seq_if aif ();

  alu_ctrl_seq #(.PC_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pc       (pc),
    .instr    (instr),
    .alu      (aif.master),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_s   (flag_s),
    .busy     (busy),
    .halted   (halted),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[pc];

  // alu: L=0 add/sub/inc/dec with carry, L=1 and/or/xor/not
  logic [4:0] sum;
  always_comb begin
    sum = 5'h00;
    if (!aif.alu_l) begin
      case (aif.alu_op)
        2'b00: sum = {1'b0, aif.alu_a} + {1'b0, aif.alu_b};
        2'b01: sum = {1'b0, aif.alu_a} + {1'b0, ~aif.alu_b} + 5'd1;
        2'b10: sum = {1'b0, aif.alu_a} + 5'd1;
        default: sum = {1'b0, aif.alu_a} + 5'h0F;
      endcase
    end else begin
      case (aif.alu_op)
        2'b00: sum = {1'b0, aif.alu_a & aif.alu_b};
        2'b01: sum = {1'b0, aif.alu_a | aif.alu_b};
        2'b10: sum = {1'b0, aif.alu_a ^ aif.alu_b};
        default: sum = {1'b0, ~aif.alu_a};
      endcase
    end
    aif.alu_r     = sum[3:0];
    aif.alu_carry = sum[4];
    aif.alu_zero  = (sum[3:0] == 4'h0);
    aif.alu_sign  = sum[3];
  end

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] sel, output logic [3:0] v);
    dbg_sel = sel;
    #1;
    v = dbg_data;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 64; i++) rom[i] = 8'hFF;
  endtask

  // Pulse start, count edges until halted. mid>=0 re-pulses start while busy.
  task automatic run(
    input  int   mid,
    output int   n,
    output bit   wrap,
    output logic busy1,
    output logic [5:0] pc1,
    output logic [3:0] a1
  );
    logic [5:0] prev;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy1 = busy;
    pc1   = pc;
    a1    = aif.alu_a;
    n     = 0;
    wrap  = 1'b0;
    prev  = pc;
    while (!halted && n < 300) begin
      start = (n == mid);
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (prev == 6'd63 && pc == 6'd0) wrap = 1'b1;
      prev = pc;
    end
  endtask

  initial begin
    int n;
    bit wrap;
    logic busy1;
    logic [5:0] pc1;
    logic [3:0] a1;
    logic [3:0] v;

    reset   = 1'b1;
    start   = 1'b0;
    dbg_sel = 2'b00;
    rom_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_pc", pc, 6'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_flags", {flag_z, flag_c, flag_s}, 3'b000);
    rd(2'd0, v); chk("rst_r0", v, 4'h0);
    rd(2'd3, v); chk("rst_r3", v, 4'h0);

    // load/add
    rom_clear();
    rom[0] = 8'h94; rom[1] = 8'h8D;
    rom[2] = 8'h01; rom[3] = 8'hFF;
    run(-1, n, wrap, busy1, pc1, a1);
    chk("add_busy_rise", busy1, 1'b1);
    chk("add_cycles", n, 12);
    chk("add_halted", halted, 1'b1);
    chk("add_busy_end", busy, 1'b0);
    chk("add_pc", pc, 6'd4);
    rd(2'd0, v); chk("add_r0", v, 4'h8);
    rd(2'd1, v); chk("add_r1", v, 4'h3);
    chk("add_flags", {flag_z, flag_c, flag_s}, 3'b001);

    // restart from HALTED: registers retained, pc back to 0
    rom_clear();
    run(-1, n, wrap, busy1, pc1, a1);
    chk("rs_busy", busy1, 1'b1);
    chk("rs_pc0", pc1, 6'd0);
    chk("rs_alu_idle", a1, 4'h0);
    chk("rs_cycles", n, 3);
    chk("rs_pc", pc, 6'd1);
    rd(2'd0, v); chk("rs_r0_kept", v, 4'h8);
    chk("rs_flags_kept", {flag_z, flag_c, flag_s}, 3'b001);

    // subtract to zero, with a start pulse while busy
    rom_clear();
    rom[0] = 8'h8E; rom[1] = 8'h8F;
    rom[2] = 8'h1B; rom[3] = 8'hFF;
    run(4, n, wrap, busy1, pc1, a1);
    chk("sub_cycles", n, 12);
    rd(2'd2, v); chk("sub_r2", v, 4'h0);
    rd(2'd3, v); chk("sub_r3", v, 4'h3);
    chk("sub_flags", {flag_z, flag_c, flag_s}, 3'b110);

    // loop: 4 iterations of SUB/JMP !Z -> 11 instructions
    rom_clear();
    rom[0] = 8'h90; rom[1] = 8'h85;
    rom[2] = 8'h11; rom[3] = 8'hDE;
    rom[4] = 8'hFF;
    run(-1, n, wrap, busy1, pc1, a1);
    chk("loop_cycles", n, 33);
    rd(2'd0, v); chk("loop_r0", v, 4'h0);
    chk("loop_z", flag_z, 1'b1);
    chk("loop_pc", pc, 6'd5);

    // PC wrap setup: R1=1, R2=14, R3=5
    rom_clear();
    rom[0] = 8'h85; rom[1] = 8'hBA;
    rom[2] = 8'h97; rom[3] = 8'hFF;
    run(-1, n, wrap, busy1, pc1, a1);
    chk("wset_cycles", n, 12);

    // ADD R2,R1; JMP !Z to 62; NOP 62,63; wrap to 0; fall through
    rom_clear();
    rom[0]  = 8'h09; rom[1]  = 8'hDC;
    rom[62] = 8'h83; rom[63] = 8'h83;
    run(-1, n, wrap, busy1, pc1, a1);
    chk("wrap_seen", wrap, 1'b1);
    chk("wrap_cycles", n, 21);
    chk("wrap_pc", pc, 6'd3);
    rd(2'd2, v); chk("wrap_r2", v, 4'h0);
    rd(2'd3, v); chk("wrap_r3", v, 4'h0);
    chk("wrap_fz_fc", {flag_z, flag_c}, 2'b11);

    // mid-EXEC reset during ADD R0,R1
    rom_clear();
    rom[0] = 8'h94; rom[1] = 8'h8D;
    rom[2] = 8'h01; rom[3] = 8'hFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mr_alu_a", aif.alu_a, 4'h5);
    chk("mr_alu_b", aif.alu_b, 4'h3);
    chk("mr_alu_op", {aif.alu_l, aif.alu_op}, 3'b000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mr_busy", busy, 1'b0);
    chk("mr_halted", halted, 1'b0);
    chk("mr_pc", pc, 6'd0);
    chk("mr_flags", {flag_z, flag_c, flag_s}, 3'b000);
    rd(2'd0, v); chk("mr_r0", v, 4'h0);
    rd(2'd1, v); chk("mr_r1", v, 4'h0);
    rd(2'd2, v); chk("mr_r2", v, 4'h0);
    rd(2'd3, v); chk("mr_r3", v, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("mr_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Multicycle control sequencer that drives the 4-bit alu from the other side of its interface. It fetches 8-bit instructions from a synchronous program ROM and decodes them. It supplies the alu operands and control lines (A, B, ALUOp, L), then consumes the alu result and flags. It owns a 4×4-bit register file, a flag register and the program counter with flag-conditional relative jumps.

## Interface
- PC_W, 6, program counter width (ROM depth 64)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  begin execution at PC=0 when IDLE or HALTED
- pc  out  6  ROM address
- instr  in  8  ROM data, valid one cycle after pc
- alu_a, alu_b  out  4  operands (to alu A, B)
- alu_op  out  2  to alu ALUOp
- alu_l  out  1  to alu L
- alu_r  in  4  alu result
- alu_zero, alu_carry, alu_sign  in  1  alu flags
- flag_z, flag_c, flag_s  out  1  latched flag register
- busy  out  1  high in FETCH/DECODE/EXEC
- halted  out  1  high in HALTED
- dbg_sel  in  2  register-file debug read select
- dbg_data  out  4  R[dbg_sel], combinational

## Operation
- Instruction classes:
  - ALU `0 L o1 o0 d1 d0 s1 s0`: A=R[d], B=R[s], alu_op=o, alu_l=L; R[d]←alu_r; Z,C,S←alu flags.
  - LOADI `10 i3..i0 d1 d0`: R[d]←imm; flags unchanged.
  - JMP `11 c1 c0 f3..f0`: if cond then PC←PC+sext(f), relative to the already-incremented PC. Conditions: 00 Z, 01 !Z, 10 C, 11 always. Flags unchanged.
  - HALT = 0xFF (always, offset −1): enter HALTED; PC is not modified.
- States: IDLE, FETCH, DECODE, EXEC, HALTED.
  - IDLE→FETCH on start; PC←0.
  - FETCH→DECODE: pc is driven and the ROM is reading.
  - DECODE→EXEC: IR←instr, PC←PC+1.
  - EXEC→FETCH after the instruction commits, or EXEC→HALTED on HALT.
  - HALTED→FETCH on start; PC←0.
- Register file and flags are retained across start; only reset clears them.
- Outside EXEC: alu_a=alu_b=0, alu_op=00, alu_l=0. alu_r and the alu flags are ignored.
- start while busy: ignored.
- Arithmetic: PC add is modulo 64 (63+1→0; 2+sext(1000)=58). alu_r is written unmodified.
- Write to the same register as the source (d==s) is legal; the operand is the pre-write value.
- dbg_data shows the register state before the EXEC-edge write.

## Timing
- Reset values: state IDLE, pc=0, IR=0, R0..R3=0, flag_z=flag_c=flag_s=0, busy=0, halted=0.
- Reset is honoured in any state, including mid-EXEC; no register or flag write occurs on that edge.
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXEC). The commit (register, flags, PC jump) happens on the clock edge leaving EXEC.
- alu_a, alu_b, alu_op and alu_l are combinational from IR and the register file during EXEC. The alu is combinational, so alu_r and the flags are sampled on the same edge.
- busy rises the cycle after start is sampled. halted rises on the edge leaving the EXEC of HALT.

## Structure
- Package ctrl_seq_pkg: state enum; class encodings (CL_ALU, CL_LOADI, CL_JMP); condition codes (CC_Z, CC_NZ, CC_C, CC_AL); HALT_INSTR=8'hFF.
- Sub-module regfile4x4:
  - two combinational read ports (a, b) plus a debug read port;
  - one synchronous write port;
  - synchronous reset to zero.
- The top holds the FSM, IR, PC, flag register and decode.

## Test plan
Bench instantiates alu_ctrl_seq, the team's alu and a behavioural 64×8 ROM.
- **Load/add:** LOADI R0,5; LOADI R1,3; ADD R0,R1 (0x01); HALT → R0=8, flag_s=1, flag_z=0, flag_c=0; halted after 12 cycles.
- **Subtract to zero:** LOADI R2,3; LOADI R3,3; SUB R2,R3 (0x1B) → R2=0, flag_z=1, flag_c=1.
- **Loop:** decrement R0 from 4 via SUB with R1=1; JMP !Z back 2 (0xDE) → exits with R0=0, loop body executed exactly 4 times.
- **PC wrap:** NOPs at 62 and 63 (LOADI R3,0) → pc goes 63→0 without stalling.
- **Mid-EXEC reset:** assert reset during EXEC of ADD → next cycle R*=0, flags=0, IDLE, pc=0, busy=0.
- **Start semantics:** start during busy → no effect. start in HALTED → restart at pc=0 with register values preserved.
